// File: rtl/aes_pkg.sv
// Shared AES-128 types, forward S-box table and GF(2^8) helpers used by
// the round datapath (encrypt_round) and its byte substitution cells.
package aes_pkg;

    typedef logic [127:0] aes_state_t;
    typedef logic [7:0]   aes_byte_t;

    // Forward S-box, entry 0 in the most significant byte, entry 255 in the least.
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Table lookup: entry b sits at bit offset (255-b)*8, i.e. {~b, 3'b000}.
    function automatic aes_byte_t sbox_lookup(input aes_byte_t b);
        logic [10:0] base;
        base = {~b, 3'b000};
        return SBOX_TABLE[base +: 8];
    endfunction

    // Multiply by x modulo x^8+x^4+x^3+x+1.
    function automatic aes_byte_t xtime(input aes_byte_t b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // One column times circulant [02 03 01 01]; byte 0 of the column in [31:24].
    function automatic logic [31:0] mix_column(input logic [31:0] col);
        aes_byte_t a0, a1, a2, a3;
        aes_byte_t b0, b1, b2, b3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
        b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
        b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
        b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        return {b0, b1, b2, b3};
    endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational forward S-box: one byte in, its substitute out.
module aes_sbox
    import aes_pkg::*;
(
    input  logic [7:0] data,
    output logic [7:0] sub
);

    assign sub = sbox_lookup(data);

endmodule

// File: rtl/encrypt_round.sv
// One registered AES-128 encryption round:
//   out <= AddRoundKey(MixColumns(ShiftRows(SubBytes(state))), key)
// Byte 0 is bits [127:120]; bytes are column-major (bytes 0..3 = column 0).
// Optional macro ENCRYPT_ROUND_FINAL_EN adds input final_round, which
// bypasses MixColumns for the last AES round.
module encrypt_round
    import aes_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    input  logic [127:0] state,
    input  logic [127:0] key,
`ifdef ENCRYPT_ROUND_FINAL_EN
    input  logic         final_round,
`endif
    output logic [127:0] out
);

    aes_state_t sub_s;
    aes_state_t shift_s;
    aes_state_t mix_s;
    aes_state_t round_s;
    aes_state_t out_r;

    // SubBytes: sixteen independent table lookups.
    for (genvar i = 0; i < 16; i++) begin : g_sbox
        aes_sbox u_sbox (
            .data (state[127 - 8*i -: 8]),
            .sub  (sub_s[127 - 8*i -: 8])
        );
    end

    // ShiftRows: row r, column c takes the byte from column (c+r) mod 4.
    for (genvar c = 0; c < 4; c++) begin : g_shift_col
        for (genvar r = 0; r < 4; r++) begin : g_shift_row
            assign shift_s[127 - 8*(4*c + r) -: 8] =
                sub_s[127 - 8*(4*((c + r) % 4) + r) -: 8];
        end
    end

    // MixColumns on each 32-bit column.
    for (genvar c = 0; c < 4; c++) begin : g_mix
        assign mix_s[127 - 32*c -: 32] = mix_column(shift_s[127 - 32*c -: 32]);
    end

    // AddRoundKey, with MixColumns skipped on the final round when enabled.
    always_comb begin
        round_s = mix_s ^ key;
`ifdef ENCRYPT_ROUND_FINAL_EN
        if (final_round) begin
            round_s = shift_s ^ key;
        end else begin
            round_s = mix_s ^ key;
        end
`endif
    end

    // Output register; reset clears the result immediately, independent of clk.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_r <= 128'h0;
        end else begin
            out_r <= round_s;
        end
    end

    assign out = out_r;

endmodule

// File: tb/tb_encrypt_round.sv
// Self-checking bench for encrypt_round: known-answer vectors plus random
// vectors scored against an arithmetic model (S-box built from GF inverse
// and affine map). Expected results are queued at drive time and popped
// one cycle later when the registered result is sampled.
module tb_encrypt_round;

    logic         clk;
    logic         rst_n;
    logic [127:0] state;
    logic [127:0] key;
    logic         final_round;
    logic [127:0] out;

    logic [127:0] exp_q[$];
    logic [7:0]   sbox_m[256];
    int           n_vectors;
    int           n_miscompares;

    encrypt_round dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .state       (state),
        .key         (key),
`ifdef ENCRYPT_ROUND_FINAL_EN
        .final_round (final_round),
`endif
        .out         (out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_vec(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vectors++;
        if (got !== exp) begin
            n_miscompares++;
            $display("FAIL %s: got %032h expected %032h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        logic       hi;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            hi = x[7];
            x = {x[6:0], 1'b0} ^ (hi ? 8'h1b : 8'h00);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    task automatic build_sbox();
        logic [7:0] inv;
        for (int i = 0; i < 256; i++) begin
            inv = 8'h00;
            for (int j = 1; j < 256; j++) begin
                if (gmul(8'(i), 8'(j)) == 8'h01) inv = 8'(j);
            end
            sbox_m[i] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [127:0] model_round(input logic [127:0] s, input logic [127:0] k, input logic fin);
        logic [7:0]   sb[16];
        logic [7:0]   sr[16];
        logic [7:0]   mc[16];
        logic [127:0] res;
        for (int i = 0; i < 16; i++) sb[i] = sbox_m[s[127 - 8*i -: 8]];
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                sr[4*c + r] = sb[4*((c + r) % 4) + r];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                mc[4*c + r] = gmul(8'h02, sr[4*c + r]) ^ gmul(8'h03, sr[4*c + (r + 1) % 4])
                            ^ sr[4*c + (r + 2) % 4] ^ sr[4*c + (r + 3) % 4];
            end
        end
        for (int i = 0; i < 16; i++) res[127 - 8*i -: 8] = (fin ? sr[i] : mc[i]) ^ k[127 - 8*i -: 8];
        return res;
    endfunction

    // Apply inputs (caller is already past a falling edge) and queue the expected result.
    task automatic put(input logic [127:0] s, input logic [127:0] k, input logic fin, input logic [127:0] exp);
        state = s;
        key = k;
        final_round = fin;
        exp_q.push_back(exp);
    endtask

    // Let the next rising edge capture, then score the oldest expectation.
    task automatic capture(input string tag);
        logic [127:0] exp;
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            check_vec({tag, "_noexp"}, out, 128'hx);
        end else begin
            exp = exp_q.pop_front();
            check_vec(tag, out, exp);
        end
    endtask

    task automatic drive(input string tag, input logic [127:0] s, input logic [127:0] k,
                         input logic fin, input logic [127:0] exp);
        @(negedge clk);
        put(s, k, fin, exp);
        capture(tag);
    endtask

    localparam logic [127:0] C1_STATE = 128'h00102030405060708090a0b0c0d0e0f0;
    localparam logic [127:0] C1_KEY   = 128'hd6aa74fdd2af72fadaa678f1d6ab76fe;
    localparam logic [127:0] C1_OUT   = 128'h89d810e8855ace682d1843d8cb128fe4;
    localparam logic [127:0] ZERO_OUT = {16{8'h63}};

    initial begin
        logic [127:0] s;
        logic [127:0] k;
        logic         fin;
        n_vectors = 0;
        n_miscompares = 0;
        rst_n = 1'b0;
        state = 128'hdeadbeef_01234567_89abcdef_a5a5a5a5;
        key = 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0;
        final_round = 1'b0;
        build_sbox();

        // Reset value before any clock edge, then held across edges.
        #3;
        check_vec("reset_noclk", out, 128'h0);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_vec("reset_held", out, 128'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;

        // Known answers and back-to-back streaming.
        drive("c1_round1", C1_STATE, C1_KEY, 1'b0, C1_OUT);
        drive("all_zero", 128'h0, 128'h0, 1'b0, ZERO_OUT);
        drive("b2b_c1", C1_STATE, C1_KEY, 1'b0, C1_OUT);
        drive("b2b_zero", 128'h0, 128'h0, 1'b0, ZERO_OUT);
        drive("c1_round2", C1_OUT, 128'hb692cf0b643dbdf1be9bc5006830b3fe, 1'b0,
              128'h4915598f55e5d7a0daca94fa1f0a63f7);
        drive("appb_round1", 128'h193de3bea0f4e22b9ac68d2ae9f84808,
              128'ha0fafe1788542cb123a339392a6c7605, 1'b0, 128'ha49c7ff2689f352b6b5bea43026a5049);
        drive("ones", {128{1'b1}}, 128'h0, 1'b0, model_round({128{1'b1}}, 128'h0, 1'b0));

        // Output holds for the whole cycle: just before the next edge it is still the last result.
        @(negedge clk);
        put(C1_STATE, C1_KEY, 1'b0, C1_OUT);
        check_vec("hold_prev", out, model_round({128{1'b1}}, 128'h0, 1'b0));
        capture("after_hold");

        // Reset mid-stream between edges, then first edge after release captures current inputs.
        drive("pre_reset", C1_STATE, C1_KEY, 1'b0, C1_OUT);
        #2;
        rst_n = 1'b0;
        #1;
        check_vec("reset_async", out, 128'h0);
        @(posedge clk);
        #1;
        check_vec("reset_mid_held", out, 128'h0);
        @(negedge clk);
        rst_n = 1'b1;
        put(128'h0, 128'h0, 1'b0, ZERO_OUT);
        capture("post_release");

`ifdef ENCRYPT_ROUND_FINAL_EN
        drive("final_round", 128'hbd6e7c3df2b5779e0b61216e8b10b689,
              128'h13111d7fe3944a17f307a78b4d2b30c5, 1'b1, 128'h69c4e0d86a7b0430d8cdb78070b4c55a);
        drive("final_off", C1_STATE, C1_KEY, 1'b0, C1_OUT);
`endif

        // Random back-to-back vectors against the arithmetic model.
        for (int n = 0; n < 24; n++) begin
            s = {$urandom, $urandom, $urandom, $urandom};
            k = {$urandom, $urandom, $urandom, $urandom};
`ifdef ENCRYPT_ROUND_FINAL_EN
            fin = 1'($urandom_range(1, 0));
`else
            fin = 1'b0;
`endif
            drive("random", s, k, fin, model_round(s, k, fin));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule
